hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 6: register-specifier width; register 0 is hardwired zero.
REQ-002 SHALL have parameter NUM_SRC, default 2: source operands checked per issued instruction.
REQ-003 SHALL have parameter DEPTH, default 3: in-flight pipeline stages tracked after decode (EX=1 .. WB=DEPTH).
REQ-004 SHALL have parameter FWD_MIN, default 2: lowest stage whose result may be forwarded; stage 1 through FWD_MIN-1 results are not yet available.
REQ-005 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-006 SHALL have port n_reset  input  1: reset, asynchronous and active-low.
REQ-007 SHALL have port issue_valid_i  input  1: decode holds a valid instruction.
REQ-008 SHALL have port issue_src_i  input  NUM_SRC*REG_WIDTH: packed source specifiers, source k at bits [k*REG_WIDTH +: REG_WIDTH].
REQ-009 SHALL have port issue_dest_i  input  REG_WIDTH: destination specifier (0 means no write).
REQ-010 SHALL have port issue_long_i  input  1: instruction is a long-latency op (load, network read) whose result arrives through completion.
REQ-011 SHALL have port cmpl_valid_i  input  1: a long-latency result is written this cycle.
REQ-012 SHALL have port cmpl_dest_i  input  REG_WIDTH: register written by the completion.
REQ-013 SHALL have port flush_i  input  1: squash all tracked stage entries (branch mispredict).
REQ-014 SHALL have port stall_o  output  1: decode must hold; no issue this cycle.
REQ-015 SHALL have port fwd_sel_o  output  NUM_SRC*$clog2(DEPTH+1): per source, 0 = register file, s = forward from stage s.
REQ-016 SHALL have port pending_cnt_o  output  REG_WIDTH+1: number of registers with an outstanding long-latency write.
REQ-017 SHALL have port err_o  output  1: sticky; set on completion to a non-pending register.

Function
REQ-018 SHALL hold a shift pipeline of DEPTH entries, each {valid, dest, long}; every cycle entry s moves to s+1, and entry DEPTH is discarded.
REQ-019 SHALL load stage 1 with {1, issue_dest_i, issue_long_i} when issue_valid_i && !stall_o, and with a bubble (valid=0) otherwise.
REQ-020 SHALL keep a 2^REG_WIDTH-bit pending vector; bit d is set when a long entry with dest d leaves stage DEPTH, and cleared when cmpl_valid_i with cmpl_dest_i=d.
REQ-021 SHALL give set priority when set and clear of the same bit coincide, leaving the bit set.
REQ-022 SHALL never set pending bit 0, and SHALL never raise a hazard on source or destination 0.
REQ-023 SHALL, per nonzero source, match against valid entries and take the youngest (lowest s) match.
REQ-024 SHALL assert stall_o combinationally when any of the following holds:
  - a youngest match has s < FWD_MIN;
  - a youngest match is long at any stage (its data is not forwardable);
  - with no match, the source's pending bit is set;
  - issue_long_i is high and issue_dest_i is pending or held in any valid long entry (WAW).
REQ-025 SHALL drive fwd_sel_o = s for a youngest non-long match with s >= FWD_MIN, and 0 otherwise; the value is don't-care while stall_o is high.
REQ-026 SHALL gate stall_o and fwd_sel_o to 0 when issue_valid_i is low.
REQ-027 SHALL, on flush_i, clear every stage entry's valid bit at the next edge, including any entry that would issue that cycle; pending bits are unaffected.
REQ-028 SHALL, on cmpl_valid_i to a non-pending register (0 included), leave state unchanged and set err_o until reset.
REQ-029 SHALL keep pending_cnt_o registered and equal to the population of the pending vector after each edge.

Reset
REQ-030 SHALL, while n_reset is low and independent of clk, clear all stage valid bits, the pending vector, pending_cnt_o and err_o.
REQ-031 SHALL, with reset asserted mid-operation, drive stall_o=0 and fwd_sel_o=0 immediately, and SHALL ignore any later completion for a pre-reset load except for setting err_o.

Verification
REQ-032 SHALL pass: issue add r5, then the next cycle an instruction with src r5 (FWD_MIN=2) -> stall_o=1 for 1 cycle, then fwd_sel=2, then issue.
REQ-033 SHALL pass: issue ALU r7, then 2 unrelated ops, then src r7 -> stall_o=0, fwd_sel=3.
REQ-034 SHALL pass: issue load r9, then src r9 -> stall_o=1 until cmpl_valid_i with cmpl_dest_i=9, then stall_o=0 and fwd_sel=0 the following cycle; pending_cnt_o goes 0->1->0.
REQ-035 SHALL pass: issue load r4 with r4 already pending -> stall_o=1 (WAW); a completion for r4 in the same cycle as a new r4 entry exits stage DEPTH -> bit 4 stays set.
REQ-036 SHALL pass: issue r3 with flush_i=1 the same cycle, then src r3 -> stall_o=0, fwd_sel=0.
REQ-037 SHALL pass: cmpl_valid_i with cmpl_dest_i=12 while nothing is pending -> err_o=1 and stays 1; n_reset=0 asynchronously -> err_o=0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-side issue/completion bundle for the hazard scoreboard
interface hazard_scoreboard_if #(
   parameter int REG_WIDTH = 6,
   parameter int NUM_SRC   = 2,
   parameter int DEPTH     = 3
);
   localparam int SELW = $clog2(DEPTH + 1);

   logic                          issue_valid_i;
   logic [NUM_SRC*REG_WIDTH-1:0]  issue_src_i;
   logic [REG_WIDTH-1:0]          issue_dest_i;
   logic                          issue_long_i;
   logic                          cmpl_valid_i;
   logic [REG_WIDTH-1:0]          cmpl_dest_i;
   logic                          flush_i;
   logic                          stall_o;
   logic [NUM_SRC*SELW-1:0]       fwd_sel_o;
   logic [REG_WIDTH:0]            pending_cnt_o;
   logic                          err_o;

   modport master (
      output issue_valid_i, issue_src_i, issue_dest_i, issue_long_i,
      output cmpl_valid_i, cmpl_dest_i, flush_i,
      input  stall_o, fwd_sel_o, pending_cnt_o, err_o
   );

   modport slave (
      input  issue_valid_i, issue_src_i, issue_dest_i, issue_long_i,
      input  cmpl_valid_i, cmpl_dest_i, flush_i,
      output stall_o, fwd_sel_o, pending_cnt_o, err_o
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW/WAW hazard detection with forwarding select and long-latency pending tracking
module hazard_scoreboard #(
   parameter int REG_WIDTH = 6,
   parameter int NUM_SRC   = 2,
   parameter int DEPTH     = 3,
   parameter int FWD_MIN   = 2
) (
   input logic clk,
   input logic n_reset,
   hazard_scoreboard_if.slave sb
);
   localparam int SELW = $clog2(DEPTH + 1);
   localparam int NREG = 1 << REG_WIDTH;

   logic [DEPTH:1]       valid_q, valid_d, long_q, long_d;
   logic [REG_WIDTH-1:0] dest_q [1:DEPTH];
   logic [REG_WIDTH-1:0] dest_d [1:DEPTH];
   logic [NREG-1:0]      pend_q, pend_d;
   logic [REG_WIDTH:0]   cnt_q, cnt_d;
   logic                 err_q, err_d;

   logic [NUM_SRC-1:0]      src_stall;
   logic [NUM_SRC*SELW-1:0] src_sel;
   logic                    waw;
   logic                    stall;
   logic                    set_en;

   function automatic logic [REG_WIDTH:0] popcount(input logic [NREG-1:0] v);
      logic [REG_WIDTH:0] c;
      c = '0;
      for (int i = 0; i < NREG; i++) c = c + {{REG_WIDTH{1'b0}}, v[i]};
      return c;
   endfunction

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      logic [REG_WIDTH-1:0] src;
      logic                 found;
      logic                 hit_long;
      logic [SELW-1:0]      hit_s;
      logic                 stall_k;
      logic [SELW-1:0]      sel_k;

      assign src = sb.issue_src_i[k*REG_WIDTH +: REG_WIDTH];

      always_comb begin
         found    = 1'b0;
         hit_long = 1'b0;
         hit_s    = '0;
         stall_k  = 1'b0;
         sel_k    = '0;
         // Scan oldest to youngest so the youngest match is the one left standing.
         for (int s = DEPTH; s >= 1; s--) begin
            if (valid_q[s] && dest_q[s] == src) begin
               found    = 1'b1;
               hit_s    = SELW'(s);
               hit_long = long_q[s];
            end
         end
         if (src != '0) begin
            if (found) begin
               if (hit_s < SELW'(FWD_MIN) || hit_long) stall_k = 1'b1;
               else                                    sel_k   = hit_s;
            end else if (pend_q[src]) begin
               stall_k = 1'b1;
            end
         end
      end

      assign src_stall[k]             = stall_k;
      assign src_sel[k*SELW +: SELW]  = sel_k;
   end

   always_comb begin
      waw = 1'b0;
      if (sb.issue_long_i && sb.issue_dest_i != '0) begin
         if (pend_q[sb.issue_dest_i]) waw = 1'b1;
         for (int s = 1; s <= DEPTH; s++) begin
            if (valid_q[s] && long_q[s] && dest_q[s] == sb.issue_dest_i) waw = 1'b1;
         end
      end
   end

   assign stall        = sb.issue_valid_i && ((|src_stall) || waw);
   assign sb.stall_o   = stall;
   assign sb.fwd_sel_o = (sb.issue_valid_i && !stall) ? src_sel : '0;
   assign sb.pending_cnt_o = cnt_q;
   assign sb.err_o     = err_q;

   assign set_en = valid_q[DEPTH] && long_q[DEPTH] && dest_q[DEPTH] != '0;

   always_comb begin
      valid_d[1] = sb.issue_valid_i && !stall && !sb.flush_i;
      dest_d[1]  = sb.issue_dest_i;
      long_d[1]  = sb.issue_long_i;
      for (int s = 2; s <= DEPTH; s++) begin
         valid_d[s] = valid_q[s-1] && !sb.flush_i;
         dest_d[s]  = dest_q[s-1];
         long_d[s]  = long_q[s-1];
      end

      pend_d = pend_q;
      err_d  = err_q;
      // A completion racing the retiring load of the same register is legal; set wins.
      if (sb.cmpl_valid_i) begin
         if (pend_q[sb.cmpl_dest_i])
            pend_d[sb.cmpl_dest_i] = 1'b0;
         else if (!(set_en && dest_q[DEPTH] == sb.cmpl_dest_i))
            err_d = 1'b1;
      end
      if (set_en) pend_d[dest_q[DEPTH]] = 1'b1;
      pend_d[0] = 1'b0;
      cnt_d     = popcount(pend_d);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         valid_q <= '0;
         long_q  <= '0;
         for (int s = 1; s <= DEPTH; s++) dest_q[s] <= '0;
         pend_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         long_q  <= long_d;
         for (int s = 1; s <= DEPTH; s++) dest_q[s] <= dest_d[s];
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
   localparam int RW = 6;
   localparam int NS = 2;
   localparam int DP = 3;
   localparam int FM = 2;

   logic clk;
   logic n_reset;
   int   errors;
   int   checks;

   hazard_scoreboard_if #(.REG_WIDTH(RW), .NUM_SRC(NS), .DEPTH(DP)) bus ();

   hazard_scoreboard #(.REG_WIDTH(RW), .NUM_SRC(NS), .DEPTH(DP), .FWD_MIN(FM)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .sb      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input int s0, input int s1, input int d, input logic lng);
      bus.issue_valid_i = v;
      bus.issue_src_i   = {RW'(s1), RW'(s0)};
      bus.issue_dest_i  = RW'(d);
      bus.issue_long_i  = lng;
   endtask

   task automatic cmpl(input logic v, input int d);
      bus.cmpl_valid_i = v;
      bus.cmpl_dest_i  = RW'(d);
   endtask

   task automatic idle(input int n);
      issue(1'b0, 0, 0, 0, 1'b0);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      n_reset = 1'b0;
      issue(1'b0, 0, 0, 0, 1'b0);
      cmpl(1'b0, 0);
      bus.flush_i = 1'b0;
      #2;
      check("rst_stall", bus.stall_o, 0);
      check("rst_fwd", bus.fwd_sel_o, 0);
      check("rst_cnt", bus.pending_cnt_o, 0);
      check("rst_err", bus.err_o, 0);
      cyc();
      cyc();
      n_reset = 1'b1;
      cyc();

      // add r5 then dependent: one stall cycle then forward from stage 2
      issue(1'b1, 0, 0, 5, 1'b0); #1;
      check("add_issue_stall", bus.stall_o, 0);
      cyc();
      issue(1'b1, 5, 0, 0, 1'b0); #1;
      check("raw_s1_stall", bus.stall_o, 1);
      cyc();
      #1;
      check("raw_s2_stall", bus.stall_o, 0);
      check("raw_s2_fwd", bus.fwd_sel_o, 2);
      cyc();
      idle(4);

      // youngest of two writers of r6 wins
      issue(1'b1, 0, 0, 6, 1'b0); cyc();
      issue(1'b1, 0, 0, 6, 1'b0); cyc();
      idle(1);
      issue(1'b1, 6, 0, 0, 1'b0); #1;
      check("youngest_fwd", bus.fwd_sel_o, 2);
      cyc();
      idle(4);

      // r7 three ops back forwards from stage 3 on source 1, r1 from stage 2 on source 0
      issue(1'b1, 0, 0, 7, 1'b0); cyc();
      issue(1'b1, 0, 0, 1, 1'b0); cyc();
      issue(1'b1, 0, 0, 2, 1'b0); cyc();
      issue(1'b1, 1, 7, 0, 1'b0); #1;
      check("alu_s3_stall", bus.stall_o, 0);
      check("alu_s3_fwd", bus.fwd_sel_o, 14);
      cyc();
      idle(4);

      // register 0 never hazards
      issue(1'b1, 0, 0, 0, 1'b0); cyc();
      issue(1'b1, 0, 0, 0, 1'b0); #1;
      check("r0_no_stall", bus.stall_o, 0);
      cyc();
      idle(4);

      // load r9 then dependent: stall until completion
      issue(1'b1, 0, 0, 9, 1'b1); #1;
      check("ld_issue_stall", bus.stall_o, 0);
      cyc();
      issue(1'b0, 9, 0, 0, 1'b0); #1;
      check("gate_invalid", bus.stall_o, 0);
      issue(1'b1, 9, 0, 0, 1'b0); #1;
      check("ld_s1_stall", bus.stall_o, 1);
      cyc();
      #1;
      check("ld_s2_stall", bus.stall_o, 1);
      cyc();
      #1;
      check("ld_s3_stall", bus.stall_o, 1);
      check("ld_cnt0", bus.pending_cnt_o, 0);
      cyc();
      #1;
      check("ld_cnt1", bus.pending_cnt_o, 1);
      check("ld_pend_stall", bus.stall_o, 1);
      cmpl(1'b1, 9); #1;
      check("ld_cmpl_stall", bus.stall_o, 1);
      cyc();
      cmpl(1'b0, 0); #1;
      check("ld_after_cnt", bus.pending_cnt_o, 0);
      check("ld_after_stall", bus.stall_o, 0);
      check("ld_after_fwd", bus.fwd_sel_o, 0);
      check("ld_no_err", bus.err_o, 0);
      cyc();
      idle(4);

      // WAW on pending r4, then completion coinciding with a new r4 retirement
      issue(1'b1, 0, 0, 4, 1'b1); cyc();
      idle(3);
      #1;
      check("waw_cnt1", bus.pending_cnt_o, 1);
      issue(1'b1, 0, 0, 4, 1'b1); #1;
      check("waw_pend_stall", bus.stall_o, 1);
      issue(1'b0, 0, 0, 0, 1'b0);
      cmpl(1'b1, 4); cyc();
      cmpl(1'b0, 0); #1;
      check("waw_clr_cnt", bus.pending_cnt_o, 0);
      issue(1'b1, 0, 0, 4, 1'b1); #1;
      check("waw_free_stall", bus.stall_o, 0);
      cyc();
      issue(1'b1, 0, 0, 4, 1'b1); #1;
      check("waw_flight_stall", bus.stall_o, 1);
      issue(1'b0, 0, 0, 0, 1'b0);
      cyc();
      cyc();
      cmpl(1'b1, 4); cyc();
      cmpl(1'b0, 0); #1;
      check("set_prio_cnt", bus.pending_cnt_o, 1);
      check("set_prio_err", bus.err_o, 0);
      issue(1'b1, 4, 0, 0, 1'b0); #1;
      check("set_prio_stall", bus.stall_o, 1);
      issue(1'b0, 0, 0, 0, 1'b0);
      cmpl(1'b1, 4); cyc();
      cmpl(1'b0, 0); #1;
      check("r4_final_cnt", bus.pending_cnt_o, 0);
      idle(4);

      // flush squashes the instruction issued in the same cycle
      bus.flush_i = 1'b1;
      issue(1'b1, 0, 0, 3, 1'b0); cyc();
      bus.flush_i = 1'b0;
      issue(1'b1, 3, 0, 0, 1'b0); #1;
      check("flush_stall", bus.stall_o, 0);
      check("flush_fwd", bus.fwd_sel_o, 0);
      cyc();
      #1;
      check("flush_s2_fwd", bus.fwd_sel_o, 0);
      idle(4);

      // reset mid-operation, then a stale completion only raises err
      issue(1'b1, 0, 0, 9, 1'b1); cyc();
      issue(1'b1, 9, 0, 0, 1'b0); #1;
      check("pre_rst_stall", bus.stall_o, 1);
      n_reset = 1'b0; #1;
      check("mid_rst_stall", bus.stall_o, 0);
      check("mid_rst_fwd", bus.fwd_sel_o, 0);
      cyc();
      n_reset = 1'b1;
      idle(4);
      cmpl(1'b1, 9); cyc();
      cmpl(1'b0, 0); #1;
      check("stale_err", bus.err_o, 1);
      check("stale_cnt", bus.pending_cnt_o, 0);
      n_reset = 1'b0; #1;
      check("stale_err_rst", bus.err_o, 0);
      cyc();
      n_reset = 1'b1;

      // completion to idle r12 sets sticky err, async reset clears it
      cmpl(1'b1, 12); cyc();
      cmpl(1'b0, 0); #1;
      check("err_set", bus.err_o, 1);
      cyc();
      check("err_sticky", bus.err_o, 1);
      #3;
      n_reset = 1'b0; #1;
      check("err_async_clr", bus.err_o, 0);
      check("err_rst_cnt", bus.pending_cnt_o, 0);
      cyc();
      n_reset = 1'b1;
      cmpl(1'b1, 0); cyc();
      cmpl(1'b0, 0); #1;
      check("err_r0_cmpl", bus.err_o, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
